// File: rtl/alu_op_sequencer.sv
// Command-queue front end for the 8-bit ALU: buffers op commands, drives the ALU, returns results.
// Optional ALU_SEQ_ECHO_EN adds rsp_a/rsp_b echoing the operands driven for each response.
module alu_op_sequencer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [6:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             alu_on,
  output logic [2:0]       alu_in_sel,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [6:0]       alu_out_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
`ifdef ALU_SEQ_ECHO_EN
  output logic [WIDTH-1:0] rsp_a,
  output logic [WIDTH-1:0] rsp_b,
`endif
  output logic [1:0]       state
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);
  localparam logic [1:0] MODE_LOAD = 2'd0;
  localparam logic [1:0] MODE_PERS = 2'd1;
  localparam logic [1:0] MODE_CLR  = 2'd2;
  localparam logic [1:0] MODE_ILL  = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, WAIT = 2'b10, RESP = 2'b11} state_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [6:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  state_t             cur, nxt;
  cmd_t               mem [DEPTH];
  cmd_t               head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  logic               full, empty, push, pop, done, head_legal;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         cur_mode;
  logic [WIDTH-1:0]   last_result, result;

  // Clear ignores the op field; every other mode needs a single op bit.
  function automatic logic is_legal(input cmd_t c);
    logic onehot;
    onehot = (c.op != 7'd0) && ((c.op & (c.op - 7'd1)) == 7'd0);
    return (c.mode != MODE_ILL) && ((c.mode == MODE_CLR) || onehot);
  endfunction

  assign state      = cur;
  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign empty      = (count == '0);
  assign cmd_ready  = rst && !full;
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem[rd_ptr];
  assign head_legal = is_legal(head);
  assign result     = (cur_mode == MODE_CLR) ? '0 : alu_out;

  always_ff @(posedge clk) begin
    if (!rst) cur <= IDLE;
    else      cur <= nxt;
  end

  always_comb begin
    nxt  = cur;
    pop  = 1'b0;
    done = 1'b0;
    case (cur)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          nxt = head_legal ? ISSUE : RESP;
        end
      end
      ISSUE: nxt = WAIT;
      WAIT: begin
        if (cnt == CNT_LAST) begin
          done = 1'b1;
          nxt  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop = 1'b1;
            nxt = head_legal ? ISSUE : RESP;
          end else begin
            nxt = IDLE;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{mode: cmd_mode, op: cmd_op, a: cmd_a, b: cmd_b};
  end

  // Latency counter restarts every ISSUE so sampling lands ALU_LAT edges into WAIT.
  always_ff @(posedge clk) begin
    if (!rst)               cnt <= '0;
    else if (cur == ISSUE)  cnt <= '0;
    else if (cur == WAIT)   cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_on      <= 1'b0;
      alu_in_sel  <= 3'b000;
      alu_num1    <= '0;
      alu_num2    <= '0;
      alu_out_sel <= 7'd0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      cur_mode    <= MODE_LOAD;
      last_result <= '0;
`ifdef ALU_SEQ_ECHO_EN
      rsp_a       <= '0;
      rsp_b       <= '0;
`endif
    end else if (pop) begin
      cur_mode <= head.mode;
      if (head_legal) begin
        alu_on    <= 1'b1;
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        case (head.mode)
          MODE_LOAD: begin
            alu_in_sel  <= 3'b010;
            alu_num1    <= head.a;
            alu_num2    <= head.b;
            alu_out_sel <= head.op;
          end
          MODE_PERS: begin
            alu_in_sel  <= 3'b001;
            alu_num1    <= last_result;
            alu_num2    <= head.b;
            alu_out_sel <= head.op;
          end
          default: begin
            alu_in_sel  <= 3'b100;
            alu_num1    <= '0;
            alu_num2    <= '0;
            alu_out_sel <= 7'd0;
          end
        endcase
      end else begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_data  <= '0;
`ifdef ALU_SEQ_ECHO_EN
        rsp_a     <= '0;
        rsp_b     <= '0;
`endif
      end
    end else if (done) begin
      alu_on      <= 1'b0;
      alu_in_sel  <= 3'b000;
      alu_num1    <= '0;
      alu_num2    <= '0;
      alu_out_sel <= 7'd0;
      rsp_valid   <= 1'b1;
      rsp_err     <= 1'b0;
      rsp_data    <= result;
      last_result <= result;
`ifdef ALU_SEQ_ECHO_EN
      rsp_a       <= alu_num1;
      rsp_b       <= alu_num2;
`endif
    end else if ((cur == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a multiply-mod-256, two-stage ALU model.
module tb_alu_op_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam logic [6:0] OP_MUL = 7'b1000000;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, alu_on, rsp_valid, rsp_ready, rsp_err;
  logic [1:0] cmd_mode, state;
  logic [6:0] cmd_op, alu_out_sel;
  logic [2:0] alu_in_sel;
  logic [WIDTH-1:0] cmd_a, cmd_b, alu_num1, alu_num2, alu_out, rsp_data;
`ifdef ALU_SEQ_ECHO_EN
  logic [WIDTH-1:0] rsp_a, rsp_b;
`endif

  alu_op_sequencer #(.WIDTH(WIDTH), .DEPTH(4), .ALU_LAT(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_on(alu_on), .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_out_sel(alu_out_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
`ifdef ALU_SEQ_ECHO_EN
    .rsp_a(rsp_a), .rsp_b(rsp_b),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  // ALU model: product of the driven operands, visible two edges later
  logic [WIDTH-1:0] alu_p1 = '0, alu_p2 = '0;
  assign alu_out = alu_p2;
  always @(posedge clk) begin
    alu_p1 <= (alu_on && alu_in_sel != 3'b100) ? WIDTH'(alu_num1 * alu_num2) : '0;
    alu_p2 <= alu_p1;
  end

  typedef struct { logic [7:0] data; logic err; logic [7:0] a; logic [7:0] b; } rsp_t;
  typedef struct { logic [2:0] in_sel; logic [7:0] n1; logic [7:0] n2; logic [6:0] op; } drv_t;

  rsp_t exp_q[$];
  drv_t drv_q[$];
  rsp_t exp_r;
  drv_t cur_drv;
  bit   have_drv = 0;
  int   checks = 0, errors = 0;
  logic [7:0] model_last = 8'd0;
  bit   mon_en = 0, rnd_ready = 0;
  logic ready_fixed = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [1:0] mode, input logic [6:0] op);
    return (mode != 2'd3) && (mode == 2'd2 || $countones(op) == 1);
  endfunction

  // Reference model: results follow command order, persist reuses the previous result.
  task automatic model_accept(input logic [1:0] mode, input logic [6:0] op,
                              input logic [7:0] a, input logic [7:0] b);
    int p;
    logic [7:0] r;
    if (!legal(mode, op)) begin
      exp_q.push_back('{8'd0, 1'b1, 8'd0, 8'd0});
    end else if (mode == 2'd0) begin
      p = int'(a) * int'(b);
      r = 8'(p % 256);
      drv_q.push_back('{3'b010, a, b, op});
      exp_q.push_back('{r, 1'b0, a, b});
      model_last = r;
    end else if (mode == 2'd1) begin
      p = int'(model_last) * int'(b);
      r = 8'(p % 256);
      drv_q.push_back('{3'b001, model_last, b, op});
      exp_q.push_back('{r, 1'b0, model_last, b});
      model_last = r;
    end else begin
      drv_q.push_back('{3'b100, 8'd0, 8'd0, 7'd0});
      exp_q.push_back('{8'd0, 1'b0, 8'd0, 8'd0});
      model_last = 8'd0;
    end
  endtask

  task automatic try_send(input logic [1:0] mode, input logic [6:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int max_cycles, output bit ok);
    bit acc;
    ok = 0;
    cmd_valid = 1'b1; cmd_mode = mode; cmd_op = op; cmd_a = a; cmd_b = b;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1;
        model_accept(mode, op, a, b);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] mode, input logic [6:0] op, input logic [7:0] a,
                      input logic [7:0] b);
    bit ok;
    try_send(mode, op, a, b, 200, ok);
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int w = 0;
    while (exp_q.size() != 0 && w < max_cycles) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end
  end

  // Response scoreboard: one expectation consumed per handshake.
  always @(negedge clk) begin
    if (mon_en && rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        exp_r = exp_q.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(exp_r.data));
        check("rsp_err", 32'(rsp_err), 32'(exp_r.err));
`ifdef ALU_SEQ_ECHO_EN
        check("rsp_a", 32'(rsp_a), 32'(exp_r.a));
        check("rsp_b", 32'(rsp_b), 32'(exp_r.b));
`endif
      end
    end
  end

  // ALU drive: new expectation in ISSUE, held through WAIT, idle elsewhere.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (state == 2'b01) begin
        if (drv_q.size() == 0) begin
          check("drv_unexpected", 32'(alu_on), 32'd0);
          have_drv = 0;
        end else begin
          cur_drv = drv_q.pop_front();
          have_drv = 1;
        end
      end
      if ((state == 2'b01 || state == 2'b10) && have_drv) begin
        check("alu_on", 32'(alu_on), 32'd1);
        check("alu_in_sel", 32'(alu_in_sel), 32'(cur_drv.in_sel));
        check("alu_num1", 32'(alu_num1), 32'(cur_drv.n1));
        check("alu_num2", 32'(alu_num2), 32'(cur_drv.n2));
        check("alu_out_sel", 32'(alu_out_sel), 32'(cur_drv.op));
      end else if (state == 2'b00 || state == 2'b11) begin
        check("alu_idle_off", 32'(alu_on), 32'd0);
      end
    end
  end

  initial begin
    bit ok;
    int lat, w, r;
    logic [1:0] md;
    logic [6:0] op;
    rst = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_op = 7'd0; cmd_a = '0; cmd_b = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_alu_on", 32'(alu_on), 32'd0);
    check("rst_alu_bus", {alu_in_sel, alu_out_sel, alu_num1, alu_num2}, 32'd0);
`ifdef ALU_SEQ_ECHO_EN
    check("rst_echo", {16'd0, rsp_a, rsp_b}, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 mon_en = 1;

    // Basic load and response latency
    send(2'd0, OP_MUL, 8'd1, 8'd2);
    lat = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid || lat > 20) break;
      @(posedge clk);
      lat++;
    end
    check("rsp_latency", 32'(lat), 32'd4);
    @(posedge clk);
    #1;
    drain(50);

    send(2'd0, OP_MUL, 8'h57, 8'h1A);
    drain(50);
    send(2'd0, OP_MUL, 8'd3, 8'd2);
    send(2'd1, OP_MUL, 8'd8, 8'd4);
    drain(50);
    send(2'd0, 7'b1100000, 8'd1, 8'd1);
    send(2'd1, OP_MUL, 8'd0, 8'd2);
    drain(50);

    // Backpressure: register plus four FIFO entries, sixth refused
    ready_fixed = 1'b0;
    cycles(2);
    send(2'd0, OP_MUL, 8'd7, 8'd9);
    send(2'd1, OP_MUL, 8'd0, 8'd3);
    send(2'd2, 7'd0, 8'd5, 8'd5);
    send(2'd3, OP_MUL, 8'd1, 8'd1);
    send(2'd1, OP_MUL, 8'd4, 8'd11);
    try_send(2'd0, OP_MUL, 8'd2, 8'd2, 4, ok);
    check("sixth_refused", 32'(ok), 32'd0);
    @(negedge clk);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1 ready_fixed = 1'b1;
    drain(100);

    // Reset while waiting on the ALU abandons the command
    send(2'd0, OP_MUL, 8'd5, 8'd5);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (state != 2'b10 && w < 20);
    check("reach_wait", 32'(state), 32'd2);
    rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    model_last = 8'd0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstw_state", 32'(state), 32'd0);
    check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cycles(10);
    check("abandoned_silent", 32'(rsp_valid), 32'd0);
    send(2'd1, OP_MUL, 8'd9, 8'd3);
    drain(50);

    // Random traffic with random response backpressure
    rnd_ready = 1;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      op = 7'(1 << $urandom_range(0, 6));
      if (r <= 3)      md = 2'd0;
      else if (r <= 6) md = 2'd1;
      else if (r == 7) md = 2'd2;
      else if (r == 8) md = 2'd3;
      else begin
        md = 2'd0;
        op = 7'($urandom_range(0, 127));
      end
      send(md, op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
    end
    drain(1000);
    rnd_ready = 0;
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
